zports_cfgbank: RTL

Parametrised, fclk-domain successor to the fixed Z80 port decoder. Hosts NCH configurable 8-bit I/O register channels, each with its own address/mask match, shadow qualification, reset value and optional write-lock. Slow channels get a wait handshake with timeout. It sits beside the Z80 bus interface, drives read data onto the internal bus and feeds paging/config logic with registered channel values.

---
 rtl/zports_cfgbank_pkg.sv | 16 +
 rtl/zports_strobe.sv | 31 +++
 rtl/zports_cfgbank.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/zports_cfgbank_pkg.sv
// Shared constants for the configurable port bank: shadow qualifier codes
// and the wait handshake state encoding.
package zports_cfgbank_pkg;

    localparam logic [1:0] SHAD_ANY   = 2'b00;
    localparam logic [1:0] SHAD_ON    = 2'b01;
    localparam logic [1:0] SHAD_OFF   = 2'b10;
    localparam logic [1:0] SHAD_NEVER = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } wait_state_t;

endpackage

// File: rtl/zports_strobe.sv
// Samples Z80 I/O read/write requests on zpos and emits one-fclk rising-edge
// pulses for each, usable by any fclk-domain port block.
module zports_strobe (
    input  logic fclk,
    input  logic rst_n,
    input  logic zpos,
    input  logic iorq_n,
    input  logic rd_n,
    input  logic wr_n,
    output logic wr_edge,
    output logic rd_edge
);

    logic [1:0] s0_reg;
    logic [1:0] s1_reg;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            s0_reg <= 2'b00;
            s1_reg <= 2'b00;
        end else begin
            if (zpos)
                s0_reg <= {~(iorq_n | wr_n), ~(iorq_n | rd_n)};
            s1_reg <= s0_reg;
        end
    end

    assign wr_edge = s0_reg[1] & ~s1_reg[1];
    assign rd_edge = s0_reg[0] & ~s1_reg[0];

endmodule

// File: rtl/zports_cfgbank.sv
// Bank of NCH address-matched 8-bit Z80 I/O registers with shadow
// qualification, write lock and a wait handshake for slow channels.
module zports_cfgbank
    import zports_cfgbank_pkg::*;
#(
    parameter int                NCH         = 4,
    parameter logic [16*NCH-1:0] CH_ADDR     = {NCH{16'h00BF}},
    parameter logic [16*NCH-1:0] CH_MASK     = {NCH{16'h00FF}},
    parameter logic [2*NCH-1:0]  CH_SHAD     = {NCH{2'b00}},
    parameter logic [8*NCH-1:0]  CH_RST      = {NCH{8'h00}},
    parameter logic [NCH-1:0]    CH_LOCKABLE = {NCH{1'b0}},
    parameter int                LOCK_CH     = 0,
    parameter int                LOCK_BIT    = 2,
    parameter logic [NCH-1:0]    CH_WAIT     = {NCH{1'b0}},
    parameter int                WAIT_TMO    = 255
) (
    input  logic             fclk,
    input  logic             rst_n,
    input  logic             zpos,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [15:0]      a,
    input  logic [7:0]       din,
    input  logic             shadow,
    output logic [7:0]       dout,
    output logic             dataout,
    output logic             porthit,
    output logic [8*NCH-1:0] regs,
    output logic [NCH-1:0]   wr_stb,
    output logic [NCH-1:0]   rd_stb,
    output logic             wait_req,
    output logic             wait_rnw,
    output logic [3:0]       wait_ch,
    output logic [7:0]       wait_wdata,
    input  logic             wait_done,
    input  logic [7:0]       wait_rdata,
    output logic             wait_tmo
);

    logic           wr_edge;
    logic           rd_edge;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] sel;
    logic [NCH-1:0] locked;
    logic [3:0]     hit_idx;
    logic [7:0]     rd_val;
    logic           hit_wait;
    logic           accept;
    logic           wr_go;
    logic           rd_go;
    logic           wait_start;
    logic           tmo_hit;
    logic [7:0]     regs_reg [NCH];
    logic [7:0]     rdbuf_reg;
    logic [15:0]    cnt_reg;
    wait_state_t    state_reg;
    wait_state_t    state_next;

    zports_strobe u_strobe (
        .fclk    (fclk),
        .rst_n   (rst_n),
        .zpos    (zpos),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .wr_edge (wr_edge),
        .rd_edge (rd_edge)
    );

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [1:0] shad;
            logic       qual;
            assign shad = CH_SHAD[2*gi +: 2];
            assign qual = (shad == SHAD_ANY) | ((shad == SHAD_ON) & shadow) |
                          ((shad == SHAD_OFF) & ~shadow);
            assign hit[gi] = (((a ^ CH_ADDR[16*gi +: 16]) & CH_MASK[16*gi +: 16]) == 16'h0000) & qual;
            assign locked[gi] = CH_LOCKABLE[gi] & regs_reg[LOCK_CH][LOCK_BIT];
            assign regs[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    // Lowest-index hit wins; scanning downwards leaves the lowest one last.
    always_comb begin
        sel     = '0;
        hit_idx = 4'd0;
        rd_val  = 8'hFF;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel     = '0;
                sel[i]  = 1'b1;
                hit_idx = 4'(i);
                rd_val  = regs_reg[i];
            end
        end
    end

    assign porthit    = |hit;
    assign hit_wait   = |(sel & CH_WAIT);
    assign accept     = porthit & (~hit_wait | (state_reg == ST_IDLE));
    assign wr_go      = wr_edge & accept;
    assign rd_go      = rd_edge & accept;
    assign wait_start = (wr_edge | rd_edge) & porthit & hit_wait & (state_reg == ST_IDLE);
    assign tmo_hit    = (cnt_reg == 16'(WAIT_TMO - 1));
    assign dataout    = porthit & ~iorq_n & ~rd_n;
    assign dout       = !porthit ? 8'hFF : (hit_wait ? rdbuf_reg : rd_val);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (wait_start)           state_next = ST_REQ;
            ST_REQ:  if (wait_done || tmo_hit) state_next = ST_HOLD;
            ST_HOLD: if (iorq_n)               state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_req = (state_reg == ST_REQ);
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                regs_reg[i] <= CH_RST[8*i +: 8];
            wr_stb     <= '0;
            rd_stb     <= '0;
            wait_rnw   <= 1'b1;
            wait_ch    <= 4'd0;
            wait_wdata <= 8'h00;
            rdbuf_reg  <= 8'hFF;
            wait_tmo   <= 1'b0;
            cnt_reg    <= 16'd0;
        end else begin
            wr_stb <= wr_go ? sel : '0;
            rd_stb <= rd_go ? sel : '0;
            for (int i = 0; i < NCH; i++)
                if (wr_go && sel[i] && !locked[i])
                    regs_reg[i] <= din;
            if (wait_start) begin
                wait_ch    <= hit_idx;
                wait_rnw   <= ~wr_edge;
                wait_wdata <= din;
                cnt_reg    <= 16'd0;
            end else if (state_reg == ST_REQ) begin
                cnt_reg <= cnt_reg + 16'd1;
            end
            // Completion takes priority over a coincident timeout.
            if (state_reg == ST_REQ) begin
                if (wait_done) begin
                    rdbuf_reg <= wait_rdata;
                end else if (tmo_hit) begin
                    rdbuf_reg <= 8'hFF;
                    wait_tmo  <= 1'b1;
                end
            end
            if (wr_go && (hit_idx == wait_ch) && din[7])
                wait_tmo <= 1'b0;
        end
    end

endmodule
